stopwatch_timer_core: RTL and testbench

Parametrised MM:SS timekeeping core for the stopwatch display path. It provides BCD count-up and count-down, per-field adjust with no carry, pause/run toggle, a countdown-expiry event and a lap hold on the displayed value. It runs entirely on clk with single-cycle tick enables from the tick generator; it does not use derived clocks. Outputs feed the 7-segment multiplexer directly.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/stopwatch_timer_core_field.sv | 63 ++++++
 rtl/stopwatch_timer_core.sv | 145 ++++++++++++++
 tb/tb_stopwatch_timer_core.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
// Two-digit BCD fields are kept as packed {tens, ones} pairs.
package stopwatch_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t tens;
      bcd_digit_t ones;
   } bcd_pair_t;

   localparam int unsigned SEC_MAX  = 59;
   localparam bcd_digit_t  BCD_NINE = 4'd9;

   function automatic int unsigned bcd_to_bin(input bcd_pair_t f);
      return (32'(f.tens) * 32'd10) + 32'(f.ones);
   endfunction

   function automatic bcd_pair_t bin_to_bcd(input int unsigned v);
      bcd_pair_t r;
      r.tens = 4'(v / 32'd10);
      r.ones = 4'(v % 32'd10);
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_timer_core_field.sv
// One two-digit BCD register counting modulo MOD_MAX+1.
// The next value is exported so the core can capture it into the display.
module bcd_field
   import stopwatch_pkg::*;
#(
   parameter int unsigned MOD_MAX = SEC_MAX
)
(
   input  logic      clk,
   input  logic      clr,
   input  logic      inc,
   input  logic      dec,
   output bcd_pair_t value,
   output bcd_pair_t next_value,
   output logic      at_max,
   output logic      at_zero,
   output logic      carry,
   output logic      borrow
);

   localparam bcd_pair_t LP_TOP = bin_to_bcd(MOD_MAX);

   bcd_pair_t r_value;
   bcd_pair_t w_next;

   assign at_max  = (r_value == LP_TOP);
   assign at_zero = (r_value == '0);

   always_comb begin
      w_next = r_value;
      if (clr) begin
         w_next = '0;
      end else if (inc) begin
         if (at_max) begin
            w_next = '0;
         end else if (r_value.ones == BCD_NINE) begin
            w_next.tens = r_value.tens + 4'd1;
            w_next.ones = '0;
         end else begin
            w_next.ones = r_value.ones + 4'd1;
         end
      end else if (dec) begin
         if (at_zero) begin
            w_next = LP_TOP;
         end else if (r_value.ones == '0) begin
            w_next.tens = r_value.tens - 4'd1;
            w_next.ones = BCD_NINE;
         end else begin
            w_next.ones = r_value.ones - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      r_value <= w_next;
   end

   assign value      = r_value;
   assign next_value = w_next;
   assign carry      = ~clr & inc & at_max;
   assign borrow     = ~clr & ~inc & dec & at_zero;

endmodule

// File: rtl/stopwatch_timer_core.sv
// MM:SS stopwatch core: BCD up/down count, per-field adjust, pause,
// countdown expiry with done pulse, and lap hold on the display.
module stopwatch_timer_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX_MIN       = 99,
   parameter bit          WRAP_UP       = 1'b1,
   parameter bit          START_RUNNING = 1'b1
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_run,
   input  logic       tick_adj,
   input  logic       pause_pulse,
   input  logic       adj,
   input  logic       sel,
   input  logic       dir,
   input  logic       lap_pulse,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       lap_active,
   output logic       expired,
   output logic       done
);

   logic      r_running;
   logic      r_lap_active;
   logic      r_expired;
   logic      r_done;
   bcd_pair_t r_disp_min;
   bcd_pair_t r_disp_sec;

   bcd_pair_t w_sec;
   bcd_pair_t w_min;
   bcd_pair_t w_sec_nxt;
   bcd_pair_t w_min_nxt;
   logic      w_sec_max, w_sec_zero, w_sec_carry, w_sec_borrow;
   logic      w_min_max, w_min_zero, w_min_carry, w_min_borrow;
   logic      w_sec_inc, w_sec_dec, w_min_inc, w_min_dec;
   logic      w_adj_step;
   logic      w_run_tick;
   logic      w_run_up;
   logic      w_live_zero;
   logic      w_at_end;
   logic      w_saturate;
   logic      w_reach_zero;
   logic      w_expire;
   logic      w_pause_ok;

   assign w_adj_step   = adj & tick_adj;
   assign w_run_tick   = ~adj & r_running & tick_run;
   assign w_live_zero  = w_sec_zero & w_min_zero;
   assign w_at_end     = w_sec_max & w_min_max;
   assign w_saturate   = w_run_tick & ~dir & w_at_end & ~WRAP_UP;
   assign w_run_up     = w_run_tick & ~dir & ~w_saturate;
   assign w_reach_zero = w_run_tick & dir & w_min_zero & (w_sec == 8'h01);
   assign w_expire     = w_saturate | w_reach_zero;

   // Restarting a down count that sits at 00:00 would expire immediately, so it is refused.
   assign w_pause_ok   = pause_pulse & ~r_expired & ~(~r_running & dir & w_live_zero);

   always_comb begin
      w_sec_inc = (w_adj_step & sel) | w_run_up;
      w_min_inc = (w_adj_step & ~sel) | (w_run_up & w_sec_carry);
      w_sec_dec = w_run_tick & dir & ~w_live_zero;
      w_min_dec = w_sec_borrow;
   end

   bcd_field #(.MOD_MAX(SEC_MAX)) u_sec (
      .clk        (clk),
      .clr        (rst),
      .inc        (w_sec_inc),
      .dec        (w_sec_dec),
      .value      (w_sec),
      .next_value (w_sec_nxt),
      .at_max     (w_sec_max),
      .at_zero    (w_sec_zero),
      .carry      (w_sec_carry),
      .borrow     (w_sec_borrow)
   );

   bcd_field #(.MOD_MAX(MAX_MIN)) u_min (
      .clk        (clk),
      .clr        (rst),
      .inc        (w_min_inc),
      .dec        (w_min_dec),
      .value      (w_min),
      .next_value (w_min_nxt),
      .at_max     (w_min_max),
      .at_zero    (w_min_zero),
      .carry      (w_min_carry),
      .borrow     (w_min_borrow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_running    <= START_RUNNING;
         r_expired    <= 1'b0;
         r_done       <= 1'b0;
         r_lap_active <= 1'b0;
         r_disp_min   <= '0;
         r_disp_sec   <= '0;
      end else begin
         r_done <= w_expire;
         if (w_expire) begin
            r_expired <= 1'b1;
            r_running <= 1'b0;
         end else begin
            if (w_adj_step) r_expired <= 1'b0;
            if (w_pause_ok) r_running <= ~r_running;
         end
         if (lap_pulse) r_lap_active <= ~r_lap_active;
         // Load next-live on both lap toggles so the capture includes this cycle's step.
         if (!r_lap_active || lap_pulse) begin
            r_disp_min <= w_min_nxt;
            r_disp_sec <= w_sec_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (bcd_to_bin(w_sec) <= SEC_MAX);
         assert (bcd_to_bin(w_min) <= MAX_MIN);
         assert (w_sec.ones <= BCD_NINE && w_min.ones <= BCD_NINE);
         if (w_min_borrow) assert (w_sec_borrow);
         if (w_min_carry && !adj) assert (w_sec_carry && WRAP_UP);
      end
   end

   assign min_tens   = r_disp_min.tens;
   assign min_ones   = r_disp_min.ones;
   assign sec_tens   = r_disp_sec.tens;
   assign sec_ones   = r_disp_sec.ones;
   assign running    = r_running;
   assign lap_active = r_lap_active;
   assign expired    = r_expired;
   // Masked so a pulse pending from the previous cycle never shows during reset.
   assign done       = r_done & ~rst;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Directed bench for stopwatch_timer_core: one wrapping and one saturating instance.
module tb_stopwatch_timer_core;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tick_run = 1'b0, tick_adj = 1'b0, pause_pulse = 1'b0;
   logic adj = 1'b0, sel = 1'b0, dir = 1'b0, lap_pulse = 1'b0;

   logic [3:0] a_mt, a_mo, a_st, a_so;
   logic       a_run, a_lap, a_exp, a_done;
   logic [3:0] s_mt, s_mo, s_st, s_so;
   logic       s_run, s_lap, s_exp, s_done;
   logic [15:0] a_disp, s_disp;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   assign a_disp = {a_mt, a_mo, a_st, a_so};
   assign s_disp = {s_mt, s_mo, s_st, s_so};

   always #5 clk = ~clk;

   stopwatch_timer_core #(.MAX_MIN(99), .WRAP_UP(1'b1), .START_RUNNING(1'b1)) dut (
      .clk(clk), .rst(rst), .tick_run(tick_run), .tick_adj(tick_adj),
      .pause_pulse(pause_pulse), .adj(adj), .sel(sel), .dir(dir), .lap_pulse(lap_pulse),
      .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
      .running(a_run), .lap_active(a_lap), .expired(a_exp), .done(a_done)
   );

   stopwatch_timer_core #(.MAX_MIN(99), .WRAP_UP(1'b0), .START_RUNNING(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .tick_run(tick_run), .tick_adj(tick_adj),
      .pause_pulse(pause_pulse), .adj(adj), .sel(sel), .dir(dir), .lap_pulse(lap_pulse),
      .min_tens(s_mt), .min_ones(s_mo), .sec_tens(s_st), .sec_ones(s_so),
      .running(s_run), .lap_active(s_lap), .expired(s_exp), .done(s_done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      tick_run = 0; tick_adj = 0; pause_pulse = 0;
      adj = 0; sel = 0; dir = 0; lap_pulse = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_run = 1;
         step();
         tick_run = 0;
      end
   endtask

   task automatic adj_steps(input logic s, input int n);
      adj = 1;
      sel = s;
      for (int i = 0; i < n; i++) begin
         tick_adj = 1;
         step();
         tick_adj = 0;
      end
      adj = 0;
   endtask

   task automatic pulse_pause();
      pause_pulse = 1;
      step();
      pause_pulse = 0;
   endtask

   task automatic pulse_lap();
      lap_pulse = 1;
      step();
      lap_pulse = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      tick_run = 1; pause_pulse = 1; lap_pulse = 1;
      rst = 1;
      step();
      rst = 0;
      clear_inputs();
      n_tests++;
      if (a_disp !== 16'h0000) begin n_fail++; $display("FAIL reset_disp: got %h want 0000", a_disp); end
      n_tests++;
      if ({a_run, a_lap, a_exp, a_done} !== 4'b1000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 1000", {a_run, a_lap, a_exp, a_done});
      end
      n_tests++;
      if ({s_disp, s_run, s_exp} !== {16'h0000, 2'b10}) begin
         n_fail++; $display("FAIL reset_sat: got %h/%b%b want 0000/10", s_disp, s_run, s_exp);
      end
   endtask

   task automatic test_up_carry();
      do_reset();
      run_ticks(61);
      n_tests++;
      if (a_disp !== 16'h0101) begin n_fail++; $display("FAIL up_61: got %h want 0101", a_disp); end
      do_reset();
      adj_steps(1'b0, 9);
      adj_steps(1'b1, 59);
      n_tests++;
      if (a_disp !== 16'h0959) begin n_fail++; $display("FAIL preset_0959: got %h want 0959", a_disp); end
      run_ticks(1);
      n_tests++;
      if (a_disp !== 16'h1000) begin n_fail++; $display("FAIL carry_1000: got %h want 1000", a_disp); end
   endtask

   task automatic test_wrap();
      do_reset();
      adj_steps(1'b0, 99);
      adj_steps(1'b1, 59);
      n_tests++;
      if (a_disp !== 16'h9959 || s_disp !== 16'h9959) begin
         n_fail++; $display("FAIL preset_9959: got %h/%h want 9959", a_disp, s_disp);
      end
      run_ticks(1);
      n_tests++;
      if (a_disp !== 16'h0000 || a_exp !== 1'b0 || a_done !== 1'b0) begin
         n_fail++; $display("FAIL wrap_up: got %h exp=%b done=%b want 0000 0 0", a_disp, a_exp, a_done);
      end
      n_tests++;
      if (s_disp !== 16'h9959 || {s_exp, s_run, s_done} !== 3'b101) begin
         n_fail++; $display("FAIL saturate: got %h exp/run/done=%b want 9959 101", s_disp, {s_exp, s_run, s_done});
      end
      run_ticks(1);
      n_tests++;
      if (s_done !== 1'b0 || s_exp !== 1'b1 || s_disp !== 16'h9959) begin
         n_fail++; $display("FAIL sat_after: got done=%b exp=%b %h want 0 1 9959", s_done, s_exp, s_disp);
      end
      adj_steps(1'b1, 1);
      n_tests++;
      if (s_exp !== 1'b0 || s_disp !== 16'h9900) begin
         n_fail++; $display("FAIL adj_clears_exp: got exp=%b %h want 0 9900", s_exp, s_disp);
      end
   endtask

   task automatic test_done_reset();
      do_reset();
      adj_steps(1'b0, 99);
      adj_steps(1'b1, 59);
      run_ticks(1);
      rst = 1;
      #1;
      n_tests++;
      if (s_done !== 1'b0) begin n_fail++; $display("FAIL done_in_rst: got %b want 0", s_done); end
      step();
      rst = 0;
      n_tests++;
      if (s_exp !== 1'b0 || s_run !== 1'b1) begin
         n_fail++; $display("FAIL rst_after_exp: got exp=%b run=%b want 0 1", s_exp, s_run);
      end
   endtask

   task automatic test_adjust();
      do_reset();
      adj_steps(1'b0, 3);
      n_tests++;
      if (a_disp !== 16'h0300) begin n_fail++; $display("FAIL adj_min3: got %h want 0300", a_disp); end
      dir = 1;
      adj_steps(1'b1, 59);
      n_tests++;
      if (a_disp !== 16'h0359) begin n_fail++; $display("FAIL adj_sec59: got %h want 0359", a_disp); end
      adj_steps(1'b1, 1);
      dir = 0;
      n_tests++;
      if (a_disp !== 16'h0300) begin n_fail++; $display("FAIL adj_nocarry: got %h want 0300", a_disp); end
   endtask

   task automatic test_countdown();
      do_reset();
      adj_steps(1'b1, 2);
      dir = 1;
      run_ticks(1);
      n_tests++;
      if (a_disp !== 16'h0001 || a_done !== 1'b0) begin
         n_fail++; $display("FAIL down_0001: got %h done=%b want 0001 0", a_disp, a_done);
      end
      run_ticks(1);
      n_tests++;
      if (a_disp !== 16'h0000 || {a_done, a_exp, a_run} !== 3'b110) begin
         n_fail++; $display("FAIL down_zero: got %h done/exp/run=%b want 0000 110", a_disp, {a_done, a_exp, a_run});
      end
      run_ticks(1);
      n_tests++;
      if (a_done !== 1'b0 || a_disp !== 16'h0000) begin
         n_fail++; $display("FAIL done_once: got done=%b %h want 0 0000", a_done, a_disp);
      end
      pulse_pause();
      n_tests++;
      if (a_run !== 1'b0) begin n_fail++; $display("FAIL pause_expired: got run=%b want 0", a_run); end
      do_reset();
      adj_steps(1'b0, 1);
      dir = 1;
      run_ticks(1);
      n_tests++;
      if (a_disp !== 16'h0059) begin n_fail++; $display("FAIL borrow: got %h want 0059", a_disp); end
      do_reset();
      dir = 1;
      run_ticks(1);
      pulse_pause();
      pulse_pause();
      n_tests++;
      if (a_run !== 1'b0 || a_disp !== 16'h0000 || a_exp !== 1'b0) begin
         n_fail++; $display("FAIL zero_start: got run=%b %h exp=%b want 0 0000 0", a_run, a_disp, a_exp);
      end
   endtask

   task automatic test_lap();
      do_reset();
      run_ticks(10);
      pulse_lap();
      n_tests++;
      if (a_lap !== 1'b1 || a_disp !== 16'h0010) begin
         n_fail++; $display("FAIL lap_on: got lap=%b %h want 1 0010", a_lap, a_disp);
      end
      run_ticks(5);
      n_tests++;
      if (a_disp !== 16'h0010) begin n_fail++; $display("FAIL lap_hold: got %h want 0010", a_disp); end
      pulse_lap();
      n_tests++;
      if (a_lap !== 1'b0 || a_disp !== 16'h0015) begin
         n_fail++; $display("FAIL lap_off: got lap=%b %h want 0 0015", a_lap, a_disp);
      end
      lap_pulse = 1; tick_run = 1;
      step();
      lap_pulse = 0; tick_run = 0;
      run_ticks(2);
      adj_steps(1'b0, 1);
      n_tests++;
      if (a_disp !== 16'h0016 || a_lap !== 1'b1) begin
         n_fail++; $display("FAIL lap_same_cycle: got %h lap=%b want 0016 1", a_disp, a_lap);
      end
      pulse_lap();
      n_tests++;
      if (a_disp !== 16'h0118) begin n_fail++; $display("FAIL lap_release: got %h want 0118", a_disp); end
   endtask

   task automatic test_reset_corner();
      do_reset();
      adj_steps(1'b0, 12);
      adj_steps(1'b1, 34);
      n_tests++;
      if (a_disp !== 16'h1234) begin n_fail++; $display("FAIL preset_1234: got %h want 1234", a_disp); end
      rst = 1; tick_run = 1;
      step();
      rst = 0; tick_run = 0;
      n_tests++;
      if (a_disp !== 16'h0000 || a_run !== 1'b1) begin
         n_fail++; $display("FAIL rst_midrun: got %h run=%b want 0000 1", a_disp, a_run);
      end
      pause_pulse = 1; tick_run = 1;
      step();
      pause_pulse = 0; tick_run = 0;
      n_tests++;
      if (a_disp !== 16'h0001 || a_run !== 1'b0) begin
         n_fail++; $display("FAIL pause_tick: got %h run=%b want 0001 0", a_disp, a_run);
      end
      run_ticks(1);
      n_tests++;
      if (a_disp !== 16'h0001) begin n_fail++; $display("FAIL paused_hold: got %h want 0001", a_disp); end
      pulse_pause();
      run_ticks(1);
      n_tests++;
      if (a_disp !== 16'h0002 || a_run !== 1'b1) begin
         n_fail++; $display("FAIL resume: got %h run=%b want 0002 1", a_disp, a_run);
      end
   endtask

   initial begin
      test_reset();
      test_up_carry();
      test_wrap();
      test_done_reset();
      test_adjust();
      test_countdown();
      test_lap();
      test_reset_corner();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
